// File: rtl/rr_arbiter_onehot_if.sv
// Grant handshake bundle between requesters and the arbiter.
// The slave modport is the arbiter side; master is the requester/consumer side.
interface rr_arbiter_onehot_if #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
);
  logic [N-1:0]  req;
  logic          grant_ready;
  logic          grant_valid;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;

  modport master (
    output req,
    output grant_ready,
    input  grant_valid,
    input  grant,
    input  grant_idx
  );

  modport slave (
    input  req,
    input  grant_ready,
    output grant_valid,
    output grant,
    output grant_idx
  );
endinterface

// File: rtl/rr_arbiter_onehot.sv
// Registered N-way arbiter, fixed highest-index or round-robin priority.
// Winner selection: reversed prefix-OR plus edge detect, once on masked
// requests and once on raw requests; masked result wins when non-empty.
module rr_arbiter_onehot #(
  parameter int N  = 8,
  parameter int RR = 1,
  parameter int IW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  rr_arbiter_onehot_if.slave  bus
);

  // Highest set bit: p[i] = |x[N-1:i] built in log2(N) shift/OR levels,
  // then keep only the bit where the prefix turns on.
  function automatic logic [N-1:0] f_highest(input logic [N-1:0] x);
    logic [N-1:0] p;
    p = x;
    for (int s = 1; s < N; s = s * 2) begin
      p = p | (p >> s);
    end
    return p & ~(p >> 1);
  endfunction

  // One-hot to binary: index bit b is the OR of all one-hot bits whose
  // position has bit b set.
  function automatic logic [IW-1:0] f_encode(input logic [N-1:0] oh);
    logic [IW-1:0] idx;
    idx = '0;
    for (int b = 0; b < IW; b++) begin
      for (int i = 0; i < N; i++) begin
        if (i[b]) idx[b] = idx[b] | oh[i];
      end
    end
    return idx;
  endfunction

  logic          r_valid;
  logic [N-1:0]  r_grant;
  logic [IW-1:0] r_idx;
  logic [N-1:0]  r_mask;

  logic          w_load;
  logic          w_accept;
  logic [N-1:0]  w_acc_mask;
  logic [N-1:0]  w_mask;
  logic [N-1:0]  w_mreq;
  logic [N-1:0]  w_oh;
  logic [IW-1:0] w_idx;

  assign w_load     = !r_valid || bus.grant_ready;
  assign w_accept   = r_valid && bus.grant_ready;
  // Bits strictly below the grant being accepted right now.
  assign w_acc_mask = (N'(1) << r_idx) - N'(1);

  // Pick the winner for the next load; an accept this cycle already
  // rotates the search so back-to-back grants descend without a bubble.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    w_mask = '1;
    if (RR != 0) begin
      w_mask = w_accept ? w_acc_mask : r_mask;
    end
    w_mreq = bus.req & w_mask;
    w_oh   = (|w_mreq) ? f_highest(w_mreq) : f_highest(bus.req);
    w_idx  = f_encode(w_oh);
  end

  // Grant registers: load a new winner when empty or accepted, else hold.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      r_valid <= 1'b0;
      r_grant <= '0;
      r_idx   <= '0;
    end else if (w_load) begin
      r_valid <= |bus.req;
      r_grant <= w_oh;
      r_idx   <= w_idx;
    end
  end

  // Rotating mask: after accepting index k only indices below k are
  // preferred; k = 0 clears it so the next search wraps to the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '1;
    end else if ((RR != 0) && w_accept) begin
      r_mask <= w_acc_mask;
    end
  end

  assign bus.grant_valid = r_valid;
  assign bus.grant       = r_grant;
  assign bus.grant_idx   = r_idx;

endmodule

// File: tb/tb_rr_arbiter_onehot.sv
// Self-checking bench: a round-robin and a fixed-priority instance share
// the same stimulus and are compared against a search-based reference.
module tb_rr_arbiter_onehot;
  localparam int N  = 8;
  localparam int IW = 3;

  typedef struct {
    bit valid;
    int idx;
    int last;   // last accepted index; N means "no preference yet"
  } model_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         ready;

  int n_assert = 0;
  int n_fail   = 0;

  model_t m_rr, m_fx;

  rr_arbiter_onehot_if #(.N(N)) if_rr ();
  rr_arbiter_onehot_if #(.N(N)) if_fx ();

  assign if_rr.req         = req;
  assign if_rr.grant_ready = ready;
  assign if_fx.req         = req;
  assign if_fx.grant_ready = ready;

  rr_arbiter_onehot #(.N(N), .RR(1)) u_rr (.clk(clk), .rst(rst), .bus(if_rr));
  rr_arbiter_onehot #(.N(N), .RR(0)) u_fx (.clk(clk), .rst(rst), .bus(if_fx));

  always #5 clk = ~clk;

  // Next requester strictly below 'last' in descending order, else the
  // highest requester overall, else none.
  function automatic int winner(input logic [N-1:0] r, input int last);
    for (int i = last - 1; i >= 0; i--) if (r[i]) return i;
    for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    return -1;
  endfunction

  function automatic model_t advance(input model_t m, input bit rr);
    model_t n;
    int     eff;
    int     w;
    n = m;
    if (rst) begin
      n.valid = 1'b0;
      n.idx   = 0;
      n.last  = N;
      return n;
    end
    eff = rr ? m.last : N;
    if (rr && m.valid && ready) begin
      eff    = m.idx;
      n.last = m.idx;
    end
    if (!m.valid || ready) begin
      w       = winner(req, eff);
      n.valid = (w >= 0);
      n.idx   = (w >= 0) ? w : 0;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string tag, input model_t m, input logic v,
                           input logic [N-1:0] g, input logic [IW-1:0] ix);
    logic [31:0] exp_g;
    exp_g = m.valid ? (32'd1 << m.idx) : 32'd0;
    check({tag, ".valid"}, 32'(v), 32'(m.valid));
    check({tag, ".grant"}, 32'(g), exp_g);
    check({tag, ".idx"}, 32'(ix), m.idx);
    check({tag, ".inv_or"}, 32'(v), 32'(|g));
    check({tag, ".inv_onehot0"}, 32'($onehot0(g)), 32'd1);
    check({tag, ".inv_shift"}, 32'(g), 32'(v) << ix);
  endtask

  task automatic step();
    model_t n_rr, n_fx;
    n_rr = advance(m_rr, 1'b1);
    n_fx = advance(m_fx, 1'b0);
    @(posedge clk);
    #1;
    m_rr = n_rr;
    m_fx = n_fx;
    check_dut("rr", m_rr, if_rr.grant_valid, if_rr.grant, if_rr.grant_idx);
    check_dut("fx", m_fx, if_fx.grant_valid, if_fx.grant, if_fx.grant_idx);
  endtask

  initial begin
    int sparse[4];
    int rr2[3];
    m_rr = '{valid: 1'b0, idx: 0, last: N};
    m_fx = '{valid: 1'b0, idx: 0, last: N};

    // Reset with all requests high
    rst = 1'b1; req = 8'hFF; ready = 1'b1;
    step(); step();
    check("reset.valid", 32'(if_rr.grant_valid), 32'd0);
    check("reset.grant", 32'(if_rr.grant), 32'd0);
    check("reset.idx", 32'(if_rr.grant_idx), 32'd0);

    // First load after reset is unmasked
    rst = 1'b0;
    step();
    check("first.grant", 32'(if_rr.grant), 32'h80);
    check("first.idx", 32'(if_rr.grant_idx), 32'd7);
    check("first.fx_grant", 32'(if_fx.grant), 32'h80);

    // Round-robin sweep continues 6..0 then wraps to 7
    for (int i = 0; i < 8; i++) begin
      step();
      check("sweep.idx", 32'(if_rr.grant_idx), 32'((14 - i) % 8));
    end

    // Fixed priority keeps picking the highest requester
    req = 8'b0010_0110;
    for (int i = 0; i < 5; i++) begin
      step();
      check("fixed.grant", 32'(if_fx.grant), 32'h20);
      check("fixed.idx", 32'(if_fx.grant_idx), 32'd5);
    end

    // Sparse round-robin from a clean reset
    rst = 1'b1; step(); rst = 1'b0;
    sparse = '{7, 0, 7, 0};
    req = 8'h81;
    for (int i = 0; i < 4; i++) begin
      step();
      check("sparse81.idx", 32'(if_rr.grant_idx), 32'(sparse[i]));
    end
    rr2 = '{5, 2, 5};
    req = 8'h24;
    for (int i = 0; i < 3; i++) begin
      step();
      check("sparse24.idx", 32'(if_rr.grant_idx), 32'(rr2[i]));
    end

    // Backpressure: held grant ignores request changes
    rst = 1'b1; step(); rst = 1'b0;
    req = 8'hFF; ready = 1'b1;
    step();
    check("bp.first", 32'(if_rr.grant), 32'h80);
    ready = 1'b0; req = 8'h01;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp.hold", 32'(if_rr.grant), 32'h80);
    end
    ready = 1'b1;
    step();
    check("bp.next", 32'(if_rr.grant), 32'h01);
    req = 8'h00;
    step();
    check("bp.empty", 32'(if_rr.grant_valid), 32'd0);

    // Reset in the middle of a round-robin run
    rst = 1'b1; step(); rst = 1'b0;
    req = 8'hFF; ready = 1'b1;
    step(); step(); step();
    check("mid.pending", 32'(if_rr.grant_idx), 32'd5);
    rst = 1'b1;
    step();
    check("mid.valid", 32'(if_rr.grant_valid), 32'd0);
    check("mid.grant", 32'(if_rr.grant), 32'd0);
    check("mid.idx", 32'(if_rr.grant_idx), 32'd0);
    rst = 1'b0;
    step();
    check("mid.after", 32'(if_rr.grant_idx), 32'd7);

    // Random traffic with backpressure and occasional resets
    for (int i = 0; i < 400; i++) begin
      req   = (i % 3 == 0) ? N'($urandom() & $urandom()) : N'($urandom());
      ready = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
